ms_shared_out_scheduler: RTL

- Round-robin scheduler that shares a single shared-variable output `sh_out` between NUM_REQ slave-style requesters.
- Each requester presents a value with a sync flag, the same pattern as an `s_in`/`s_in_sync` pair.
- Two-phase sequencing: section_a arbitrates and captures one value; section_b publishes it for HOLD_CYCLES cycles.
- Sits between producer blocks and the consumer of the shared output.

---
 rtl/ms_shared_out_scheduler_pkg.sv | 17 +
 rtl/ms_rr_picker.sv | 29 ++
 rtl/ms_shared_out_scheduler.sv | 126 ++++++++++++
 3 files changed

// File: rtl/ms_shared_out_scheduler_pkg.sv
// Shared types for the shared-output scheduler: phase enum, stats width and a
// helper that sizes index/counter fields safely for small parameter values.
package ms_shared_out_scheduler_types;

  typedef enum logic {
    section_a = 1'b0,
    section_b = 1'b1
  } Phases;

  localparam int STATS_W = 16;

  // Bits needed to hold 0..n-1, never less than one.
  function automatic int grant_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ms_rr_picker.sv
// Combinational round-robin picker: first set request strictly after the last
// granted index, wrapping modulo NUM_REQ.
module ms_rr_picker
  import ms_shared_out_scheduler_types::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]          req,
  input  logic [grant_w(NUM_REQ)-1:0] last,
  output logic                        any_req,
  output logic [grant_w(NUM_REQ)-1:0] winner
);

  localparam int GW = grant_w(NUM_REQ);

  always_comb begin
    any_req = |req;
    winner  = last;
    // Scan from highest to lowest priority offset so the nearest request wins.
    for (int k = NUM_REQ; k >= 1; k--) begin
      int idx;
      idx = (int'(last) + k) % NUM_REQ;
      if (req[idx]) begin
        winner = GW'(idx);
      end
    end
  end

endmodule

// File: rtl/ms_shared_out_scheduler.sv
// Round-robin scheduler sharing one output between NUM_REQ requesters.
// Optional per-requester grant counters: define MS_SHARED_OUT_SCHED_STATS_EN.
module ms_shared_out_scheduler
  import ms_shared_out_scheduler_types::*;
#(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 32,
  parameter int HOLD_CYCLES = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [NUM_REQ*DATA_W-1:0]   req_val,
  input  logic [NUM_REQ-1:0]          req_sync,
  output logic [NUM_REQ-1:0]          req_ack,
  output logic [DATA_W-1:0]           sh_out,
  output logic                        sh_out_valid,
  output logic [grant_w(NUM_REQ)-1:0] grant_id,
  output Phases                       phase
`ifdef MS_SHARED_OUT_SCHED_STATS_EN
  ,
  output logic [NUM_REQ*STATS_W-1:0]  grant_cnt
`endif
);

  localparam int GW     = grant_w(NUM_REQ);
  localparam int HOLD_W = grant_w(HOLD_CYCLES);

  logic                any_req;
  logic [GW-1:0]       winner;
  logic [DATA_W-1:0]   winner_val;

  logic [DATA_W-1:0]   val_reg;
  logic [HOLD_W-1:0]   hold_cnt;

  Phases               phase_nxt;
  logic [DATA_W-1:0]   val_nxt;
  logic [DATA_W-1:0]   sh_out_nxt;
  logic                valid_nxt;
  logic [NUM_REQ-1:0]  ack_nxt;
  logic [GW-1:0]       grant_nxt;
  logic [HOLD_W-1:0]   hold_nxt;

  ms_rr_picker #(
    .NUM_REQ (NUM_REQ)
  ) u_picker (
    .req     (req_sync),
    .last    (grant_id),
    .any_req (any_req),
    .winner  (winner)
  );

  // Only the winner's slice is routed onward, so unknowns elsewhere stay put.
  assign winner_val = req_val[winner*DATA_W +: DATA_W];

  always_comb begin
    phase_nxt  = phase;
    val_nxt    = val_reg;
    sh_out_nxt = sh_out;
    valid_nxt  = sh_out_valid;
    ack_nxt    = '0;
    grant_nxt  = grant_id;
    hold_nxt   = hold_cnt;
    case (phase)
      section_a: begin
        valid_nxt = 1'b0;
        if (any_req) begin
          val_nxt    = winner_val;
          sh_out_nxt = winner_val;
          grant_nxt  = winner;
          ack_nxt    = NUM_REQ'(1) << winner;
          valid_nxt  = 1'b1;
          hold_nxt   = HOLD_W'(HOLD_CYCLES - 1);
          phase_nxt  = section_b;
        end
      end
      section_b: begin
        if (hold_cnt == '0) begin
          phase_nxt = section_a;
          valid_nxt = 1'b0;
        end else begin
          hold_nxt = hold_cnt - 1'b1;
        end
      end
      default: phase_nxt = section_a;
    endcase
  end

  // Grant pointer resets to the last index so the first search begins at 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      phase        <= section_a;
      val_reg      <= '0;
      sh_out       <= '0;
      sh_out_valid <= 1'b0;
      req_ack      <= '0;
      grant_id     <= GW'(NUM_REQ - 1);
      hold_cnt     <= '0;
    end else begin
      phase        <= phase_nxt;
      val_reg      <= val_nxt;
      sh_out       <= sh_out_nxt;
      sh_out_valid <= valid_nxt;
      req_ack      <= ack_nxt;
      grant_id     <= grant_nxt;
      hold_cnt     <= hold_nxt;
    end
  end

`ifdef MS_SHARED_OUT_SCHED_STATS_EN
  // Saturating per-requester grant counters driven by the registered ack.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (req_ack[i] && (grant_cnt[i*STATS_W +: STATS_W] != {STATS_W{1'b1}})) begin
          grant_cnt[i*STATS_W +: STATS_W] <= grant_cnt[i*STATS_W +: STATS_W] + 1'b1;
        end
      end
    end
  end
`else
  // No statistics state in this build.
`endif

endmodule
